// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution over a raster image held in external synchronous RAM.
// One feed slot per cycle, zero padding by coordinate, shift/clamp or abs output, full-pipeline stall.
module conv3x3_stream_engine #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 6,
  parameter int IMG_W  = 30,
  parameter int IMG_H  = 30,
  parameter int ADDR_W = 10,
  localparam int ACC_W = PIX_W + COEF_W + 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_mode,
  input  logic [3:0]               i_shift,
  input  logic                     i_coef_we,
  input  logic [3:0]               i_coef_idx,
  input  logic signed [COEF_W-1:0] i_coef_data,
  output logic [ADDR_W-1:0]        o_rd_addr,
  input  logic [PIX_W-1:0]         i_rd_data,
  input  logic                     i_out_ready,
  output logic [PIX_W-1:0]         o_pix_out,
  output logic signed [ACC_W-1:0]  o_acc_out,
  output logic                     o_pix_valid,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [1:0]               o_dbg_state
);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NSLOT  = NPIX + IMG_W + 1;
  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int SR_N   = 2 * IMG_W + 2;
  localparam int SLOT_W = $clog2(NSLOT + 1);
  localparam int OUT_W  = $clog2(NPIX + 1);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(NSLOT - 1);
  localparam logic [SLOT_W-1:0] C_NPIX_S    = SLOT_W'(NPIX);
  localparam logic [SLOT_W-1:0] C_ADDR_LAST = SLOT_W'(NPIX - 1);
  localparam logic [SLOT_W-1:0] C_FIRST_OUT = SLOT_W'(IMG_W + 1);
  localparam logic [OUT_W-1:0]  C_OUT_LAST  = OUT_W'(NPIX - 1);
  localparam logic [ROW_W-1:0]  C_ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  C_COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic signed [ACC_W-1:0] C_MAX_S = ACC_W'((1 << PIX_W) - 1);
  localparam logic [ACC_W-1:0]        C_MAX_U = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [SLOT_W-1:0]        r_slot;
  logic [ADDR_W-1:0]        r_addr;
  logic [OUT_W-1:0]         r_out_cnt;
  logic [ROW_W-1:0]         r_cr;
  logic [COL_W-1:0]         r_cc;
  logic                     r_mode;
  logic [3:0]               r_shift;
  logic                     r_s1_valid, r_s1_real, r_s1_out, r_p_valid, r_s_valid;
  logic                     r_stall_d;
  logic [PIX_W-1:0]         r_hold;
  logic [PIX_W-1:0]         r_sr [0:SR_N-1];
  logic [PIX_W-1:0]         w_win [0:SR_N];
  logic signed [COEF_W-1:0] r_coef [0:8];
  logic signed [PROD_W-1:0] r_prod [0:8];
  logic signed [PROD_W-1:0] w_prod [0:8];
  logic signed [ACC_W-1:0]  r_sum, w_sum, w_shr;
  logic [ACC_W-1:0]         w_mag, w_mag_sh;
  logic [PIX_W-1:0]         w_pix, w_fed;
  logic                     w_stall, w_en, w_issue, w_last_hs;

  // Handshake: a result transfers on o_pix_valid & i_out_ready; when o_pix_valid is high and
  // i_out_ready is low the whole engine (address, counters, window, pipeline, outputs) freezes.
  assign w_stall   = o_pix_valid & ~i_out_ready;
  assign w_en      = ~w_stall;
  assign w_issue   = (r_state == S_RUN) & w_en;
  assign w_last_hs = o_pix_valid & i_out_ready & (r_out_cnt == C_OUT_LAST);
  assign o_rd_addr = r_addr;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   begin
        o_busy = 1'b1;
        if (w_issue && r_slot == C_SLOT_LAST) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_last_hs) w_next = S_DONE;
      end
      S_DONE:  begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) r_coef[k] <= '0;
      r_coef[4] <= COEF_W'(1);
    end else if (i_coef_we && !o_busy && i_coef_idx <= 4'd8) begin
      r_coef[i_coef_idx] <= i_coef_data;
    end
  end

  // The RAM keeps reading the held next address during a stall, so the word owed to the
  // in-flight slot is captured on the first stall cycle and replayed until the slot is consumed.
  assign w_fed = !r_s1_real ? '0 : (r_stall_d ? r_hold : i_rd_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0; r_addr <= '0; r_out_cnt <= '0; r_cr <= '0; r_cc <= '0;
      r_mode <= 1'b0; r_shift <= '0; r_stall_d <= 1'b0; r_hold <= '0;
      r_s1_valid <= 1'b0; r_s1_real <= 1'b0; r_s1_out <= 1'b0;
    end else begin
      r_stall_d <= w_stall;
      if (w_stall && !r_stall_d) r_hold <= i_rd_data;
      if (o_pix_valid && i_out_ready) r_out_cnt <= r_out_cnt + OUT_W'(1);
      if (w_en) begin
        r_s1_valid <= w_issue;
        r_s1_real  <= (r_slot < C_NPIX_S);
        r_s1_out   <= (r_slot >= C_FIRST_OUT);
        if (w_issue) begin
          r_slot <= r_slot + SLOT_W'(1);
          if (r_slot < C_ADDR_LAST) r_addr <= r_addr + ADDR_W'(1);
        end
        if (r_s1_valid && r_s1_out) begin
          if (r_cc == C_COL_LAST) begin
            r_cc <= '0;
            r_cr <= r_cr + ROW_W'(1);
          end else begin
            r_cc <= r_cc + COL_W'(1);
          end
        end
      end
      if (r_state == S_IDLE && i_start) begin
        r_slot <= '0; r_addr <= '0; r_out_cnt <= '0; r_cr <= '0; r_cc <= '0;
        r_mode <= i_mode; r_shift <= i_shift;
      end
    end
  end

  // w_win[j] is the pixel fed j slots before the current one; the centre sits at IMG_W+1.
  always_comb begin
    w_win[0] = w_fed;
    for (int i = 1; i <= SR_N; i++) w_win[i] = r_sr[i-1];
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if ((dr == 0 && r_cr == '0) || (dr == 2 && r_cr == C_ROW_LAST) ||
            (dc == 0 && r_cc == '0) || (dc == 2 && r_cc == C_COL_LAST))
          w_prod[dr*3+dc] = '0;
        else
          w_prod[dr*3+dc] = PROD_W'($signed({1'b0, w_win[SR_N - dr*IMG_W - dc]})) *
                            PROD_W'(r_coef[dr*3+dc]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_en && r_s1_valid) begin
      for (int i = 0; i < SR_N; i++) r_sr[i] <= w_win[i];
    end
    if (w_en && r_s1_valid && r_s1_out) begin
      for (int k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < 9; k++) w_sum = w_sum + ACC_W'(r_prod[k]);
  end

  always_comb begin
    w_shr    = r_sum >>> r_shift;
    w_mag    = r_sum[ACC_W-1] ? ACC_W'(-r_sum) : ACC_W'(r_sum);
    w_mag_sh = w_mag >> r_shift;
    w_pix    = '0;
    if (r_mode) begin
      w_pix = (w_mag_sh > C_MAX_U) ? '1 : w_mag_sh[PIX_W-1:0];
    end else if (!w_shr[ACC_W-1]) begin
      w_pix = (w_shr > C_MAX_S) ? '1 : w_shr[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_valid <= 1'b0; r_s_valid <= 1'b0; r_sum <= '0;
      o_pix_valid <= 1'b0; o_pix_out <= '0; o_acc_out <= '0;
    end else if (w_en) begin
      r_p_valid   <= r_s1_valid & r_s1_out;
      r_s_valid   <= r_p_valid;
      o_pix_valid <= r_s_valid;
      if (r_p_valid) r_sum <= w_sum;
      if (r_s_valid) begin
        o_pix_out <= w_pix;
        o_acc_out <= r_sum;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Bench for conv3x3_stream_engine: RAM model, frame-level reference convolution,
// expected-value queues drained by a monitor on every output handshake.
module tb_conv3x3_stream_engine;
  localparam int PIX_W = 8, COEF_W = 6, IMG_W = 30, IMG_H = 30, ADDR_W = 10;
  localparam int ACC_W = PIX_W + COEF_W + 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0, i_mode = 1'b0, i_coef_we = 1'b0, i_out_ready = 1'b1;
  logic [3:0] i_shift = '0, i_coef_idx = '0;
  logic signed [COEF_W-1:0] i_coef_data = '0;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [PIX_W-1:0] i_rd_data = '0, o_pix_out;
  logic signed [ACC_W-1:0] o_acc_out;
  logic o_pix_valid, o_busy, o_done;
  logic [1:0] o_dbg_state;

  logic [PIX_W-1:0] mem [0:(1<<ADDR_W)-1];
  int kern [0:8];
  logic [PIX_W-1:0] exp_pix_q[$];
  logic [ACC_W-1:0] exp_acc_q[$];
  int n_vec = 0, n_err = 0, n_out = 0, done_cnt = 0;
  bit mon_en = 1'b1, rand_ready = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) i_rd_data <= mem[o_rd_addr];

  conv3x3_stream_engine #(.PIX_W(PIX_W), .COEF_W(COEF_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
                          .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode), .i_shift(i_shift),
    .i_coef_we(i_coef_we), .i_coef_idx(i_coef_idx), .i_coef_data(i_coef_data),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_out_ready(i_out_ready),
    .o_pix_out(o_pix_out), .o_acc_out(o_acc_out), .o_pix_valid(o_pix_valid),
    .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state));

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      i_out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  endtask

  task automatic monitor();
    bit prev_stall = 1'b0;
    logic [PIX_W-1:0] prev_pix = '0, ep;
    logic [ACC_W-1:0] prev_acc = '0, ea;
    forever begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (mon_en) begin
        if (prev_stall) begin
          n_vec++;
          if (o_pix_out != prev_pix || o_acc_out != prev_acc) begin
            n_err++;
            $display("FAIL stall_hold: pix %0d acc %0d, held values pix %0d acc %0d",
                     o_pix_out, o_acc_out, prev_pix, prev_acc);
          end
        end
        if (o_pix_valid && i_out_ready) begin
          n_vec++;
          n_out++;
          if (exp_pix_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_output: pix %0d acc %0d with nothing expected", o_pix_out, o_acc_out);
          end else begin
            ep = exp_pix_q.pop_front();
            ea = exp_acc_q.pop_front();
            if (o_pix_out != ep || o_acc_out != ea) begin
              n_err++;
              $display("FAIL output_%0d: pix %0d acc %0d, expected pix %0d acc %0d",
                       n_out, o_pix_out, $signed(o_acc_out), ep, $signed(ea));
            end
          end
        end
      end
      prev_stall = mon_en && o_pix_valid && !i_out_ready;
      prev_pix = o_pix_out;
      prev_acc = o_acc_out;
    end
  endtask

  task automatic write_coef(input int idx, input int val);
    @(posedge clk); #1;
    i_coef_we = 1'b1; i_coef_idx = 4'(idx); i_coef_data = COEF_W'(val);
    @(posedge clk); #1;
    i_coef_we = 1'b0;
    if (idx <= 8) kern[idx] = val;
  endtask

  task automatic set_identity();
    for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 1 : 0);
  endtask

  // Reference: direct 3x3 sum with out-of-image taps skipped, then shift/clamp or abs.
  task automatic build_expected(input bit md, input int sh);
    int acc, v;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        acc = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (r+dr >= 0 && r+dr < IMG_H && c+dc >= 0 && c+dc < IMG_W)
              acc += int'(mem[(r+dr)*IMG_W + c+dc]) * kern[(dr+1)*3 + dc+1];
        if (!md) begin
          v = acc >>> sh;
          if (v < 0) v = 0;
        end else begin
          v = ((acc < 0) ? -acc : acc) >> sh;
        end
        if (v > 255) v = 255;
        exp_pix_q.push_back(8'(v));
        exp_acc_q.push_back(18'(acc));
      end
    end
  endtask

  task automatic run_frame(input bit md, input int sh, input bit rr, input bit chk_lat,
                           input bit busy_wr, input bit start_wr, input int sw_idx, input int sw_val);
    int lat, guard;
    rand_ready = rr;
    if (start_wr && sw_idx <= 8) kern[sw_idx] = sw_val;
    build_expected(md, sh);
    done_cnt = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = md; i_shift = 4'(sh);
    if (start_wr) begin
      i_coef_we = 1'b1; i_coef_idx = 4'(sw_idx); i_coef_data = COEF_W'(sw_val);
    end
    @(posedge clk); #1;
    i_start = 1'b0; i_coef_we = 1'b0;
    chk("busy_rise", o_busy, 1);
    chk("first_addr", o_rd_addr, 0);
    lat = 0;
    while (!o_pix_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (chk_lat) chk("first_valid_latency", lat, IMG_W + 5);
    if (busy_wr) begin
      i_coef_we = 1'b1; i_coef_idx = 4'd4; i_coef_data = '0;
      @(posedge clk); #1;
      i_coef_we = 1'b0;
    end
    guard = 0;
    while (!o_done && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("done_within_budget", (guard < 5000) ? 1 : 0, 1);
    chk("busy_low_at_done", o_busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("all_outputs_seen", exp_pix_q.size(), 0);
    exp_pix_q.delete();
    exp_acc_q.delete();
    rand_ready = 1'b0;
  endtask

  initial begin
    int guard, base;
    for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 1 : 0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 8'(i % 256);
    fork
      ready_driver();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_pix_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_pix", o_pix_out, 0);
    chk("rst_acc", o_acc_out, 0);
    rst = 1'b0;

    run_frame(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'd10;
    for (int k = 0; k < 9; k++) write_coef(k, 1);
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
    mem[15*IMG_W + 15] = 8'd200;
    write_coef(4, -8);
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_frame(1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i % 256);
    set_identity();
    run_frame(1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 9; k++) write_coef(k, int'($urandom_range(0, 63)) - 32);
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    end

    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i % 256);
    set_identity();
    write_coef(12, 5);
    run_frame(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    run_frame(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 3);

    write_coef(4, 2);
    write_coef(0, 1);
    build_expected(1'b0, 0);
    done_cnt = 0;
    base = n_out;
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = 1'b0; i_shift = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    guard = 0;
    while (n_out < base + 400 && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reached_output_400", (guard < 3000) ? 1 : 0, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", o_pix_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_pix", o_pix_out, 0);
    chk("midrst_acc", o_acc_out, 0);
    chk("midrst_addr", o_rd_addr, 0);
    rst = 1'b0;
    exp_pix_q.delete();
    exp_acc_q.delete();
    for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 1 : 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    mon_en = 1'b1;
    base = n_out;
    run_frame(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("restart_output_count", n_out - base, NPIX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
